// File: rtl/dual_cpu_ram_arbiter.sv
// Two-CPU arbiter for one shared synchronous RAM. Each access takes four
// cycles (IDLE, ACCESS, LATCH, DONE). When both CPUs request together, the
// side that was not served last time is granted.
module dual_cpu_ram_arbiter #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_rw,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_hold,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_rw,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_hold,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, LATCH, DONE} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          ram_we_q, ram_we_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          grant_b;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    rd_d        = rd_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    grant_b     = b_req & (~a_req | prio_q);
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          owner_d     = grant_b;
          rd_d        = grant_b ? b_rw : a_rw;
          ram_addr_d  = grant_b ? b_addr : a_addr;
          ram_wdata_d = grant_b ? b_wdata : a_wdata;
          ram_we_d    = grant_b ? ~b_rw : ~a_rw;
          state_d     = ACCESS;
        end
      end
      ACCESS: state_d = LATCH;
      LATCH: begin
        // RAM output is valid now, one clock after the address was presented
        if (rd_q) begin
          if (owner_q) b_rdata_d = ram_rdata;
          else         a_rdata_d = ram_rdata;
        end
        a_ack_d = ~owner_q;
        b_ack_d = owner_q;
        state_d = DONE;
      end
      DONE: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      rd_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      rd_q        <= rd_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  // Each CPU is stalled until its ack strobe; ack is 0 in reset, so hold follows req.
  assign a_hold    = a_req & ~a_ack_q;
  assign b_hold    = b_req & ~b_ack_q;
endmodule

// File: tb/tb_dual_cpu_ram_arbiter.sv
// Bench for dual_cpu_ram_arbiter: a behavioural synchronous RAM plus a scoreboard
// of expected completions (owner side and read data) popped on each ack.
module tb_dual_cpu_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_rw, b_req, b_rw;
  logic [10:0] a_addr, b_addr, ram_addr;
  logic [7:0]  a_wdata, b_wdata, a_rdata, b_rdata, ram_wdata, ram_rdata;
  logic        a_hold, a_ack, b_hold, b_ack, ram_we;

  logic [7:0]  mem [0:2047];
  logic [7:0]  ref_mem [0:2047];
  logic        bd_we = 1'b0;
  logic [10:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  typedef struct packed {logic side; logic rd; logic [7:0] data;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_cpu_ram_arbiter #(.AW(11), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_hold(a_hold), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_hold(b_hold), .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous RAM, read data one clock after the address; backdoor port for preload.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic preload(input logic [10:0] addr, input logic [7:0] data);
    bd_we = 1'b1; bd_addr = addr; bd_data = data;
    ref_mem[addr] = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic drive(input logic side, input logic rw, input logic [10:0] addr,
                       input logic [7:0] wd);
    exp_t e;
    if (rw) e = '{side: side, rd: 1'b1, data: ref_mem[addr]};
    else begin
      ref_mem[addr] = wd;
      e = '{side: side, rd: 1'b0, data: 8'h00};
    end
    sb.push_back(e);
    if (side) begin b_req = 1'b1; b_rw = rw; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1'b1; a_rw = rw; a_addr = addr; a_wdata = wd; end
  endtask

  function automatic exp_t sb_pop(output logic empty);
    exp_t e;
    empty = (sb.size() == 0);
    e = '0;
    if (!empty) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1; a_req = 1'b1; b_req = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b want 0", ram_we); end
    checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL rst_a_ack got %b want 0", a_ack); end
    checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL rst_a_hold got %b want 1", a_hold); end
    checks++; if (a_rdata !== 8'h00) begin errors++; $display("FAIL rst_a_rdata got %h want 00", a_rdata); end
    checks++; if (b_hold !== 1'b0) begin errors++; $display("FAIL rst_b_hold got %b want 0", b_hold); end
    checks++; if (ram_addr !== 11'h0) begin errors++; $display("FAIL rst_ram_addr got %h want 000", ram_addr); end
    @(negedge clk);
    a_req = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  // One uncontended access with cycle-exact checks; called at a negedge in IDLE.
  task automatic test_single(input logic side, input logic rw, input logic [10:0] addr,
                             input logic [7:0] wd);
    exp_t e; logic empty; logic obs_ack, oth_ack, obs_hold; logic [7:0] obs_rd;
    drive(side, rw, addr, wd);
    for (int c = 0; c < 4; c++) begin
      #1;
      obs_ack  = side ? b_ack : a_ack;
      oth_ack  = side ? a_ack : b_ack;
      obs_hold = side ? b_hold : a_hold;
      obs_rd   = side ? b_rdata : a_rdata;
      if (c < 3) begin
        checks++; if (obs_hold !== 1'b1) begin errors++; $display("FAIL single_hold c%0d got %b want 1", c, obs_hold); end
      end
      if (c == 1) begin
        checks++; if (ram_addr !== addr) begin errors++; $display("FAIL single_addr got %h want %h", ram_addr, addr); end
        checks++; if (ram_we !== ~rw) begin errors++; $display("FAIL single_we got %b want %b", ram_we, ~rw); end
        if (!rw) begin
          checks++; if (ram_wdata !== wd) begin errors++; $display("FAIL single_wdata got %h want %h", ram_wdata, wd); end
        end
      end
      if (c == 2) begin
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL single_we_latch got %b want 0", ram_we); end
      end
      if (c == 3) begin
        checks++; if (obs_ack !== 1'b1 || oth_ack !== 1'b0) begin errors++; $display("FAIL single_ack got %b/%b want 1/0", obs_ack, oth_ack); end
        checks++; if (obs_hold !== 1'b0) begin errors++; $display("FAIL single_hold_done got %b want 0", obs_hold); end
        e = sb_pop(empty);
        checks++; if (empty) begin errors++; $display("FAIL single_sb got empty want entry"); end
        else if (e.rd) begin
          checks++; if (obs_rd !== e.data) begin errors++; $display("FAIL single_rdata got %h want %h", obs_rd, e.data); end
        end
        if (side) b_req = 1'b0; else a_req = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous;
    exp_t e; logic empty;
    rst = 1'b1; #1; rst = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b0, 11'h7FF, 8'hC3);
    drive(1'b1, 1'b1, 11'h7FF, 8'h00);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c == 1) begin
        checks++; if (ram_we !== 1'b1 || ram_addr !== 11'h7FF) begin errors++; $display("FAIL sim_write got we=%b addr=%h want 1/7ff", ram_we, ram_addr); end
      end
      if (c < 7) begin
        checks++; if (b_hold !== 1'b1 || b_ack !== 1'b0) begin errors++; $display("FAIL sim_b_wait c%0d got hold=%b ack=%b want 1/0", c, b_hold, b_ack); end
      end
      checks++; if (a_ack !== (c == 3)) begin errors++; $display("FAIL sim_a_ack c%0d got %b want %b", c, a_ack, c == 3); end
      if (a_ack || b_ack) begin
        e = sb_pop(empty);
        checks++; if (empty || e.side !== b_ack) begin errors++; $display("FAIL sim_order got side %b want %b", b_ack, e.side); end
        if (e.rd) begin
          checks++; if (b_rdata !== e.data) begin errors++; $display("FAIL sim_b_rdata got %h want %h", b_rdata, e.data); end
        end
        if (a_ack) a_req = 1'b0;
        if (b_ack) b_req = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sim_left got %0d want 0", sb.size()); end
  endtask

  task automatic test_alternate;
    exp_t e; logic empty; int acks = 0;
    preload(11'h010, 8'hA1);
    preload(11'h020, 8'hB2);
    drive(1'b0, 1'b1, 11'h010, 8'h00);
    drive(1'b1, 1'b1, 11'h020, 8'h00);
    sb.push_back(sb[0]);
    sb.push_back(sb[1]);
    for (int c = 0; c < 16; c++) begin
      #1;
      checks++; if ((a_ack | b_ack) !== (c % 4 == 3) || (a_ack & b_ack)) begin
        errors++; $display("FAIL alt_ack c%0d got a=%b b=%b want strobe=%b", c, a_ack, b_ack, c % 4 == 3); end
      if (a_ack || b_ack) begin
        acks++;
        e = sb_pop(empty);
        checks++; if (empty || e.side !== b_ack) begin errors++; $display("FAIL alt_order ack%0d got side %b want %b", acks, b_ack, e.side); end
        checks++; if ((b_ack ? b_rdata : a_rdata) !== e.data) begin
          errors++; $display("FAIL alt_rdata got %h want %h", b_ack ? b_rdata : a_rdata, e.data); end
      end
      if (c == 15) begin a_req = 1'b0; b_req = 1'b0; end
      @(negedge clk);
    end
    checks++; if (acks != 4) begin errors++; $display("FAIL alt_count got %0d want 4", acks); end
  endtask

  task automatic test_reset_abort;
    exp_t e; logic empty;
    test_single(1'b0, 1'b1, 11'h010, 8'h00);
    a_req = 1'b1; a_rw = 1'b0; a_addr = 11'h055; a_wdata = 8'h99;
    @(negedge clk); #1;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL abort_we_pre got %b want 1", ram_we); end
    #1 rst = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL abort_we got %b want 0", ram_we); end
    checks++; if (a_hold !== 1'b1) begin errors++; $display("FAIL abort_hold got %b want 1", a_hold); end
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack c%0d got %b want 0", c, a_ack); end
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 11'h020, 8'h00);
    drive(1'b1, 1'b1, 11'h010, 8'h00);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c == 3) begin
        checks++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin errors++; $display("FAIL abort_prio got a=%b b=%b want 1/0", a_ack, b_ack); end
      end
      if (a_ack || b_ack) begin
        e = sb_pop(empty);
        checks++; if (empty || e.side !== b_ack || (b_ack ? b_rdata : a_rdata) !== e.data) begin
          errors++; $display("FAIL abort_sb got side %b data %h want %b %h", b_ack, b_ack ? b_rdata : a_rdata, e.side, e.data); end
        if (a_ack) a_req = 1'b0;
        if (b_ack) b_req = 1'b0;
      end
      @(negedge clk);
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_isolation;
    exp_t e; logic empty;
    preload(11'h0AA, 8'h11);
    test_single(1'b1, 1'b1, 11'h0AA, 8'h00);
    drive(1'b0, 1'b0, 11'h0AA, 8'h77);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (b_rdata !== 8'h11 || b_ack !== 1'b0) begin
        errors++; $display("FAIL iso_b c%0d got rdata=%h ack=%b want 11/0", c, b_rdata, b_ack); end
      if (a_ack) begin
        e = sb_pop(empty);
        checks++; if (empty || c != 3) begin errors++; $display("FAIL iso_a_ack got cycle %0d want 3", c); end
        a_req = 1'b0;
      end
      @(negedge clk);
    end
    test_single(1'b0, 1'b1, 11'h0AA, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_rw = 1'b1; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_rw = 1'b1; b_addr = '0; b_wdata = '0;
    @(negedge clk);
    test_reset;
    preload(11'h123, 8'h5A);
    test_single(1'b0, 1'b1, 11'h123, 8'h00);
    test_simultaneous;
    test_alternate;
    test_reset_abort;
    test_isolation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
